// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the EX/MEM slot types.
// Default widths for ex_mem_reg; the slot struct is sized from these.
package pipe_pkg;

    localparam int DATA_W = 3;
    localparam int ADDR_W = 3;
    localparam int REG_W  = 3;

    typedef struct packed {
        logic valid;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } ex_mem_ctrl_t;

    typedef struct packed {
        ex_mem_ctrl_t          ctrl;
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     store_data;
        logic [REG_W-1:0]      rd;
    } ex_mem_t;

endpackage

// File: rtl/sat_counter.sv
// 8-bit event counter that stops at all-ones instead of wrapping.
module sat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] count
);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (en)
            count <= sat_inc(count);
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall, flush, illegal-control trap, EX forwarding
// and load-use detection. Define EX_MEM_PERF_EN to add stall/bubble counters.
module ex_mem_reg #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int ADDR_W = pipe_pkg::ADDR_W,
    parameter int REG_W  = pipe_pkg::REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    input  logic              ex_mem_to_reg,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              stall,
    input  logic              flush,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    output logic              mem_read_ctrl,
    output logic              mem_write_ctrl,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_write,
    output logic              mem_valid,
    output logic              mem_reg_write,
    output logic              mem_mem_to_reg,
    output logic [REG_W-1:0]  mem_rd,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic              load_use_hazard,
    output logic              ctrl_err
`ifdef EX_MEM_PERF_EN
    ,
    output logic [7:0]        stall_cnt,
    output logic [7:0]        bubble_cnt
`endif
);
    import pipe_pkg::*;

    ex_mem_t ex_mem_nxt;
    ex_mem_t ex_mem_p0;
    logic    illegal;
    logic    load_bubble;
    logic    vld_p0;

    // Read+write together is a decode bug; it enters the pipe as a bubble.
    assign illegal     = ex_valid & ex_mem_read & ex_mem_write;
    assign load_bubble = ~ex_valid | illegal;

    always_comb begin
        ex_mem_nxt            = '0;
        ex_mem_nxt.alu_result = ex_alu_result;
        ex_mem_nxt.store_data = ex_store_data;
        ex_mem_nxt.rd         = ex_rd;
        if (!load_bubble) begin
            ex_mem_nxt.ctrl.valid      = 1'b1;
            ex_mem_nxt.ctrl.mem_read   = ex_mem_read;
            ex_mem_nxt.ctrl.mem_write  = ex_mem_write;
            ex_mem_nxt.ctrl.reg_write  = ex_reg_write;
            ex_mem_nxt.ctrl.mem_to_reg = ex_mem_to_reg;
        end
    end

    // ---- EX -> MEM boundary ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem_p0 <= '0;
            ctrl_err  <= 1'b0;
        end else if (flush) begin
            ex_mem_p0.ctrl <= '0;
        end else if (!stall) begin
            ex_mem_p0 <= ex_mem_nxt;
            if (illegal)
                ctrl_err <= 1'b1;
        end
    end

    assign vld_p0         = ex_mem_p0.ctrl.valid;
    assign mem_valid      = vld_p0;
    assign mem_read_ctrl  = vld_p0 & ex_mem_p0.ctrl.mem_read;
    assign mem_write_ctrl = vld_p0 & ex_mem_p0.ctrl.mem_write;
    assign mem_reg_write  = ex_mem_p0.ctrl.reg_write;
    assign mem_mem_to_reg = ex_mem_p0.ctrl.mem_to_reg;
    assign mem_address    = ex_mem_p0.alu_result[ADDR_W-1:0];
    assign mem_data_write = ex_mem_p0.store_data;
    assign mem_rd         = ex_mem_p0.rd;
    assign mem_alu_result = ex_mem_p0.alu_result;

    // Only ALU results are ready here; loaded data arrives a stage later.
    assign fwd_valid = vld_p0 & ex_mem_p0.ctrl.reg_write & ~ex_mem_p0.ctrl.mem_to_reg
                     & (ex_mem_p0.rd != '0);
    assign fwd_rd    = ex_mem_p0.rd;
    assign fwd_data  = ex_mem_p0.alu_result;

    assign load_use_hazard = vld_p0 & mem_read_ctrl & ex_mem_p0.ctrl.reg_write
                           & (ex_mem_p0.rd != '0)
                           & ((ex_mem_p0.rd == id_rs1) | (ex_mem_p0.rd == id_rs2));

`ifdef EX_MEM_PERF_EN
    logic stall_en;
    logic bubble_en;

    assign stall_en  = stall & ~flush;
    assign bubble_en = flush | (~stall & load_bubble);

    sat_counter u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_en),
        .count (stall_cnt)
    );

    sat_counter u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (bubble_en),
        .count (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed scenarios plus randomized traffic
// against a slot-level reference model.
module tb_ex_mem_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
    logic [2:0] ex_alu_result, ex_store_data, ex_rd;
    logic       stall, flush;
    logic [2:0] id_rs1, id_rs2;
    logic       mem_read_ctrl, mem_write_ctrl, mem_valid, mem_reg_write, mem_mem_to_reg;
    logic [2:0] mem_address, mem_data_write, mem_rd, mem_alu_result;
    logic       fwd_valid, load_use_hazard, ctrl_err;
    logic [2:0] fwd_rd, fwd_data;
`ifdef EX_MEM_PERF_EN
    logic [7:0] stall_cnt, bubble_cnt;
`endif

    always #5 clk = ~clk;

    ex_mem_reg dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .stall(stall), .flush(flush), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .mem_read_ctrl(mem_read_ctrl), .mem_write_ctrl(mem_write_ctrl),
        .mem_address(mem_address), .mem_data_write(mem_data_write),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_mem_to_reg(mem_mem_to_reg), .mem_rd(mem_rd),
        .mem_alu_result(mem_alu_result), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .load_use_hazard(load_use_hazard), .ctrl_err(ctrl_err)
`ifdef EX_MEM_PERF_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference slot: what instruction currently sits in MEM, by meaning.
    bit m_valid, m_load, m_store, m_wb, m_from_mem, m_err;
    int m_alu, m_sd, m_rd;
    int m_stalls, m_bubbles;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_load = 0; m_store = 0; m_wb = 0; m_from_mem = 0; m_err = 0;
        m_alu = 0; m_sd = 0; m_rd = 0; m_stalls = 0; m_bubbles = 0;
    endtask

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // Apply one clock edge's worth of pipeline rules to the reference slot.
    task automatic model_edge();
        if (flush) begin
            m_valid = 0; m_load = 0; m_store = 0; m_wb = 0; m_from_mem = 0;
            m_bubbles = sat(m_bubbles);
        end else if (stall) begin
            m_stalls = sat(m_stalls);
        end else begin
            bit real_insn;
            real_insn = ex_valid && !(ex_mem_read && ex_mem_write);
            if (ex_valid && ex_mem_read && ex_mem_write) m_err = 1;
            if (!real_insn) m_bubbles = sat(m_bubbles);
            m_valid    = real_insn;
            m_load     = real_insn && ex_mem_read;
            m_store    = real_insn && ex_mem_write;
            m_wb       = real_insn && ex_reg_write;
            m_from_mem = real_insn && ex_mem_to_reg;
            m_alu = ex_alu_result; m_sd = ex_store_data; m_rd = ex_rd;
        end
    endtask

    task automatic chk_all();
        bit exp_fwd, exp_haz;
        exp_fwd = m_valid && m_wb && !m_from_mem && m_rd != 0;
        exp_haz = m_valid && m_load && m_wb && m_rd != 0 &&
                  (m_rd == int'(id_rs1) || m_rd == int'(id_rs2));
        chk("valid",    mem_valid,       m_valid);
        chk("rd_strobe", mem_read_ctrl,  m_load);
        chk("wr_strobe", mem_write_ctrl, m_store);
        chk("ctrl_err", ctrl_err,        m_err);
        chk("fwd_valid", fwd_valid,      exp_fwd);
        chk("hazard",   load_use_hazard, exp_haz);
        if (m_valid) begin
            chk("reg_write",  mem_reg_write,  m_wb);
            chk("mem_to_reg", mem_mem_to_reg, m_from_mem);
            chk("address",    mem_address,    m_alu);
            chk("wdata",      mem_data_write, m_sd);
            chk("rd",         mem_rd,         m_rd);
            chk("alu",        mem_alu_result, m_alu);
        end
        if (exp_fwd) begin
            chk("fwd_rd",   fwd_rd,   m_rd);
            chk("fwd_data", fwd_data, m_alu);
        end
`ifdef EX_MEM_PERF_EN
        chk("stall_cnt",  stall_cnt,  m_stalls);
        chk("bubble_cnt", bubble_cnt, m_bubbles);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk_all();
    endtask

    task automatic set_ex(input bit v, input bit r, input bit w, input bit rw,
                          input bit m2r, input int alu, input int sd, input int rd);
        ex_valid = v; ex_mem_read = r; ex_mem_write = w; ex_reg_write = rw;
        ex_mem_to_reg = m2r; ex_alu_result = 3'(alu); ex_store_data = 3'(sd);
        ex_rd = 3'(rd);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, mem_valid, 0);
        chk({tag, "_rds"},   mem_read_ctrl, 0);
        chk({tag, "_wrs"},   mem_write_ctrl, 0);
        chk({tag, "_addr"},  mem_address, 0);
        chk({tag, "_wdata"}, mem_data_write, 0);
        chk({tag, "_rd"},    mem_rd, 0);
        chk({tag, "_alu"},   mem_alu_result, 0);
        chk({tag, "_rw"},    mem_reg_write, 0);
        chk({tag, "_fwd"},   fwd_valid, 0);
        chk({tag, "_haz"},   load_use_hazard, 0);
        chk({tag, "_err"},   ctrl_err, 0);
`ifdef EX_MEM_PERF_EN
        chk({tag, "_scnt"},  stall_cnt, 0);
        chk({tag, "_bcnt"},  bubble_cnt, 0);
`endif
    endtask

    initial begin
        int bub_before;
        rst = 1'b1; stall = 0; flush = 0; id_rs1 = 0; id_rs2 = 0;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        chk_zero("por");
        @(negedge clk); rst = 1'b0;

        // Store then load to the same address
        set_ex(1, 0, 1, 0, 0, 5, 3, 0);
        step();
        chk("st_wr", mem_write_ctrl, 1);
        chk("st_addr", mem_address, 5);
        chk("st_data", mem_data_write, 3);
        set_ex(1, 1, 0, 1, 1, 5, 0, 2);
        step();
        chk("ld_rd", mem_read_ctrl, 1);
        chk("ld_wr", mem_write_ctrl, 0);

        // Hold the load for three edges while EX changes underneath
        stall = 1;
        set_ex(1, 0, 1, 1, 0, 7, 6, 5);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_rd", mem_read_ctrl, 1);
            chk("stall_rdidx", mem_rd, 2);
        end
        flush = 1;
        step();
        chk("flush_valid", mem_valid, 0);
        chk("flush_rd", mem_read_ctrl, 0);
        chk("flush_wr", mem_write_ctrl, 0);
        stall = 0; flush = 0;

        // Forwarding
        set_ex(1, 0, 0, 1, 0, 6, 0, 4);
        step();
        chk("fwd_v", fwd_valid, 1);
        chk("fwd_rd4", fwd_rd, 4);
        chk("fwd_d6", fwd_data, 6);
        set_ex(1, 0, 0, 1, 0, 6, 0, 0);
        step();
        chk("fwd_r0", fwd_valid, 0);

        // Load-use
        set_ex(1, 1, 0, 1, 1, 1, 0, 3);
        id_rs1 = 0; id_rs2 = 3;
        step();
        chk("lu_hit", load_use_hazard, 1);
        id_rs1 = 1; id_rs2 = 2; #1;
        chk("lu_miss", load_use_hazard, 0);
        chk_all();

        // Illegal read+write
        bub_before = m_bubbles;
        set_ex(1, 1, 1, 1, 0, 2, 2, 1);
        step();
        chk("ill_valid", mem_valid, 0);
        chk("ill_rd", mem_read_ctrl, 0);
        chk("ill_wr", mem_write_ctrl, 0);
        chk("ill_err", ctrl_err, 1);
`ifdef EX_MEM_PERF_EN
        chk("ill_bcnt", bubble_cnt, bub_before + 1);
`endif
        set_ex(1, 0, 0, 1, 0, 3, 0, 5);
        step(); step();
        chk("err_sticky", ctrl_err, 1);

        // Reset asserted mid-cycle with a load held on the inputs
        set_ex(1, 1, 0, 1, 1, 4, 0, 6);
        stall = 1;
        @(posedge clk); model_edge(); #3;
        rst = 1'b1; #1;
        model_reset();
        chk_zero("mid_rst");
        @(negedge clk); rst = 1'b0; stall = 0;
        step();
        chk("post_rst_rd", mem_read_ctrl, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_ex(($urandom_range(9, 0) < 8), $urandom_range(1, 0), $urandom_range(1, 0),
                   $urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(7, 0),
                   $urandom_range(7, 0), $urandom_range(7, 0));
            stall  = ($urandom_range(3, 0) == 0);
            flush  = ($urandom_range(9, 0) == 0);
            id_rs1 = 3'($urandom_range(7, 0));
            id_rs2 = 3'($urandom_range(7, 0));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX/MEM pipeline register between the execute stage and the data-memory stage.
- Captures the EX result, store data, destination register and control bits on each rising edge.
- Drives the memory stage's read/write strobes, address and write data, plus writeback-side control.
- Supports stall (hold), flush (bubble insertion) and illegal-control detection, and provides EX forwarding and a load-use hazard flag to decode.

Parameters:
DATA_W, 3, width of ALU result, store data and memory data
ADDR_W, 3, memory address width; address = alu_result[ADDR_W-1:0]
REG_W, 3, register-file index width

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
ex_valid  in  1  EX holds a real instruction
ex_mem_read  in  1  instruction is a load
ex_mem_write  in  1  instruction is a store
ex_reg_write  in  1  instruction writes the register file
ex_mem_to_reg  in  1  writeback source is memory (1) or ALU (0)
ex_alu_result  in  DATA_W  ALU result / effective address
ex_store_data  in  DATA_W  store operand
ex_rd  in  REG_W  destination register
stall  in  1  hold current contents
flush  in  1  replace next contents with a bubble
id_rs1, id_rs2  in  REG_W  decode-stage source registers
mem_read_ctrl  out  1  read strobe to the memory stage
mem_write_ctrl  out  1  write strobe to the memory stage
mem_address  out  ADDR_W  memory address
mem_data_write  out  DATA_W  store data
mem_valid  out  1  slot holds a real instruction
mem_reg_write, mem_mem_to_reg  out  1  passed to MEM/WB
mem_rd  out  REG_W  passed to MEM/WB
mem_alu_result  out  DATA_W  passed to MEM/WB
fwd_valid  out  1  fwd_data is forwardable to EX
fwd_rd  out  REG_W  forwarded register index
fwd_data  out  DATA_W  forwarded ALU value
load_use_hazard  out  1  decode must stall one cycle
ctrl_err  out  1  sticky illegal-control flag

Behaviour:
- Reset (async, immediate): every registered output is 0, including all strobes, valid, ctrl_err and the data fields. fwd_valid and load_use_hazard are 0 as a consequence.
- Update priority at each posedge is rst > flush > stall > load.
  - flush: valid and all control bits are cleared. Data fields may hold any value; the bench checks only the strobes and valid.
  - stall without flush: all registers hold.
  - load: all fields are captured from the ex_* inputs.
- Latency: EX inputs at posedge N appear on the outputs after posedge N. The memory stage samples on the following falling edge, so the outputs are stable a half cycle before use.
- Illegal control: ex_valid with both ex_mem_read and ex_mem_write set.
  - The instruction is captured as a bubble (valid=0, all control 0).
  - ctrl_err sets and stays set until rst.
- Strobes are gated by valid:
  - mem_read_ctrl = mem_valid & read bit.
  - mem_write_ctrl = mem_valid & write bit.
  - The two strobes are never both 1.
- ex_valid=0 loads a bubble, and ex_* control bits are ignored.
- fwd_valid = mem_valid & mem_reg_write & ~mem_mem_to_reg & (mem_rd != 0). fwd_rd = mem_rd; fwd_data = mem_alu_result. Combinational from registers.
- load_use_hazard = mem_valid & mem_read_ctrl & mem_reg_write & (mem_rd != 0) & (mem_rd == id_rs1 | mem_rd == id_rs2). Combinational.
- Register 0 never forwards or raises a hazard.
- Stall held over several cycles: strobes stay asserted. Re-reads are harmless; a held store rewrites the same value to the same address.
- rst asserted mid-stall or mid-flush: outputs clear immediately. Normal loading resumes on the first posedge after rst deasserts.

Optional Feature:
- EX_MEM_PERF_EN defined: adds outputs stall_cnt[7:0] and bubble_cnt[7:0].
  - stall_cnt increments on each posedge with stall=1 and flush=0.
  - bubble_cnt increments on each posedge that loads a bubble (flush, ex_valid=0, or illegal control).
  - Both saturate at 255 and clear on rst.
- Undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds the DATA_W/ADDR_W/REG_W constants and the typedefs ex_mem_ctrl_t (valid, mem_read, mem_write, reg_write, mem_to_reg) and ex_mem_t (ctrl, alu_result, store_data, rd).
- One natural sub-module, sat_counter (8-bit saturating, enable input), instantiated twice under EX_MEM_PERF_EN.

Test Plan:
- Reset: assert rst mid-cycle with a load held → all outputs 0 immediately; ctrl_err=0.
- Store then load:
  - Store (alu_result=5, store_data=3): after the next posedge, mem_write_ctrl=1, mem_address=5, mem_data_write=3.
  - Following load to address 5: mem_read_ctrl=1, mem_write_ctrl=0.
- Stall 3 cycles on a load (rd=2), then flush together with stall:
  - Outputs hold for 3 posedges.
  - The flush edge gives mem_valid=0 and both strobes 0.
- Forwarding: ALU op rd=4, alu_result=6 → fwd_valid=1, fwd_rd=4, fwd_data=6. Same op with rd=0 → fwd_valid=0.
- Load-use: load rd=3, id_rs2=3 → load_use_hazard=1. With id_rs1=1, id_rs2=2 → 0.
- Illegal read+write with ex_valid=1:
  - Bubble captured: strobes 0, mem_valid=0.
  - ctrl_err=1 and remains 1 across subsequent loads until rst.
  - With EX_MEM_PERF_EN, bubble_cnt increments by 1.
